// File: rtl/syn_pulse_gen.sv
// rtl/syn_pulse_gen.sv - multi-channel sync pulse generator with programmable delay/width
// Optional holdoff guard after each pulse: define SYN_PULSE_HOLDOFF_EN.
module syn_pulse_gen #(
   parameter int CH_NUM      = 4,
   parameter int CNT_W       = 8,
   parameter int RETRIG      = 1,
   parameter int HOLDOFF_CYC = 4
) (
   input  logic                    clkin,
   input  logic                    rst,
   input  logic [CH_NUM-1:0]       trig,
   input  logic [CH_NUM*CNT_W-1:0] delay_cfg,
   input  logic [CH_NUM*CNT_W-1:0] width_cfg,
   output logic [CH_NUM-1:0]       syn_out,
   output logic [CH_NUM-1:0]       busy,
   output logic [CH_NUM-1:0]       done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DELAY  = 2'd1,
`ifdef SYN_PULSE_HOLDOFF_EN
      S_ACTIVE = 2'd2,
      S_HOLD   = 2'd3
`else
      S_ACTIVE = 2'd2
`endif
   } state_t;

`ifdef SYN_PULSE_HOLDOFF_EN
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLDOFF_CYC);
`else
   logic [31:0] unused_holdoff;
   assign unused_holdoff = HOLDOFF_CYC;
`endif

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] wid_q, wid_d;
      logic             syn_q, busy_q, done_q;
      logic             syn_d, busy_d, done_d;
      logic             fin;
      logic [CNT_W-1:0] d_in, w_in;

      assign d_in = delay_cfg[i*CNT_W +: CNT_W];
      assign w_in = width_cfg[i*CNT_W +: CNT_W];

      // State, counter, latched width and registered outputs; reset wins over everything
      always_ff @(posedge clkin) begin
         if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            wid_q   <= CNT_ZERO;
            syn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wid_q   <= wid_d;
            syn_q   <= syn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
         end
      end

      // Next-state: the delay is only needed at acceptance, so it loads the counter directly
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         wid_d   = wid_q;
         fin     = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (trig[i]) begin
                  wid_d = w_in;
                  if (d_in != CNT_ZERO) begin
                     state_d = S_DELAY;
                     cnt_d   = d_in;
                  end else if (w_in != CNT_ZERO) begin
                     state_d = S_ACTIVE;
                     cnt_d   = w_in;
                  end else begin
                     fin = 1'b1;
                  end
               end
            end
            S_DELAY: begin
               if (cnt_q == CNT_ONE) begin
                  if (wid_q != CNT_ZERO) begin
                     state_d = S_ACTIVE;
                     cnt_d   = wid_q;
                  end else begin
                     fin = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            S_ACTIVE: begin
               // A retrigger takes priority even on the cycle that would have ended the pulse
               if ((RETRIG != 0) && trig[i]) begin
                  cnt_d = wid_q;
               end else if (cnt_q == CNT_ONE) begin
                  fin = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
`ifdef SYN_PULSE_HOLDOFF_EN
            S_HOLD: begin
               if (cnt_q <= CNT_ONE) begin
                  state_d = S_IDLE;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
`endif
            default: begin
               state_d = S_IDLE;
               cnt_d   = CNT_ZERO;
            end
         endcase
         if (fin) begin
`ifdef SYN_PULSE_HOLDOFF_EN
            if (HOLD_LD != CNT_ZERO) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               state_d = S_IDLE;
               cnt_d   = CNT_ZERO;
            end
`else
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
`endif
         end
      end

      // Output decode from the next state so the registered outputs line up with it
      always_comb begin
         syn_d  = (state_d == S_ACTIVE);
         busy_d = (state_d != S_IDLE);
         done_d = fin;
      end

      assign syn_out[i] = syn_q;
      assign busy[i]    = busy_q;
      assign done[i]    = done_q;
   end

endmodule

// File: tb/tb_syn_pulse_gen.sv
// tb/tb_syn_pulse_gen.sv - self-checking bench for syn_pulse_gen (retrigger and one-shot builds)
module tb_syn_pulse_gen;

`ifdef SYN_PULSE_HOLDOFF_EN
   localparam int HOLD = 4;
`else
   localparam int HOLD = 0;
`endif

   logic        clkin = 1'b0;
   logic        rst;
   logic [3:0]  trig;
   logic [31:0] dcfg, wcfg;
   logic [3:0]  syn_r, busy_r, done_r;
   logic [3:0]  syn_o, busy_o, done_o;

   int total = 0;
   int bad   = 0;
   int n     = 0;

   // model: per channel, edge numbers of acceptance, pulse start and completion
   int st [2][4];
   int as [2][4];
   int en [2][4];
   int mw [2][4];

   always #5 clkin = ~clkin;

   syn_pulse_gen #(.CH_NUM(4), .CNT_W(8), .RETRIG(1), .HOLDOFF_CYC(4)) dut_r (
      .clkin(clkin), .rst(rst), .trig(trig), .delay_cfg(dcfg), .width_cfg(wcfg),
      .syn_out(syn_r), .busy(busy_r), .done(done_r));

   syn_pulse_gen #(.CH_NUM(4), .CNT_W(8), .RETRIG(0), .HOLDOFF_CYC(4)) dut_o (
      .clkin(clkin), .rst(rst), .trig(trig), .delay_cfg(dcfg), .width_cfg(wcfg),
      .syn_out(syn_o), .busy(busy_o), .done(done_o));

   typedef struct {
      logic [3:0]  t;
      logic [31:0] d;
      logic [31:0] w;
      logic [3:0]  es;
      logic [3:0]  eb;
      logic [3:0]  ed;
   } vec_t;

   task automatic chk(input string nm, input int a, input int e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, a, e);
      end
   endtask

   task automatic model_edge(input logic r, input logic [3:0] t);
      n++;
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < 4; c++) begin
            if (r) begin
               st[m][c] = -100; as[m][c] = -100; en[m][c] = -100;
            end else if (t[c]) begin
               if (n > en[m][c] + HOLD) begin
                  st[m][c] = n;
                  as[m][c] = n + int'(dcfg[c*8 +: 8]);
                  mw[m][c] = int'(wcfg[c*8 +: 8]);
                  en[m][c] = as[m][c] + mw[m][c];
               end else if (m == 0 && mw[m][c] > 0 && as[m][c] < n && n <= en[m][c]) begin
                  en[m][c] = n + mw[m][c];
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [3:0] es, eb, ed;
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < 4; c++) begin
            es[c] = (mw[m][c] > 0) && (as[m][c] <= n) && (n < en[m][c]);
            eb[c] = (st[m][c] <= n) && (n < en[m][c] + HOLD);
            ed[c] = (n == en[m][c]);
         end
         chk($sformatf("m%0d_syn@%0d", m, n), (m == 0) ? syn_r : syn_o, es);
         chk($sformatf("m%0d_busy@%0d", m, n), (m == 0) ? busy_r : busy_o, eb);
         chk($sformatf("m%0d_done@%0d", m, n), (m == 0) ? done_r : done_o, ed);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] t);
      rst  = r;
      trig = t;
      @(posedge clkin);
      model_edge(r, t);
      #1;
      compare_all();
   endtask

   vec_t vt [16];
   int   cs, cd, cs2, cd2;

   initial begin
      rst = 1'b1; trig = '0; dcfg = '0; wcfg = '0;
      for (int m = 0; m < 2; m++)
         for (int c = 0; c < 4; c++) begin
            st[m][c] = -100; as[m][c] = -100; en[m][c] = -100; mw[m][c] = 0;
         end

      // reset held with triggers asserted, then release
      wcfg = 32'h01010101;
      step(1'b1, 4'hF);
      chk("rst_busy", busy_r, 0);
      step(1'b1, 4'hF);
      chk("rst_syn", syn_r | syn_o, 0);
      step(1'b0, 4'hF);
      chk("release_busy", busy_r, 4'hF);
      chk("release_syn", syn_o, 4'hF);
      for (int i = 0; i < 4; i++) step(1'b0, 4'h0);

`ifndef SYN_PULSE_HOLDOFF_EN
      vt[0]  = '{4'b0001, 32'h00000003, 32'h00000005, 4'b0000, 4'b0001, 4'b0000};
      vt[1]  = '{4'b0000, 32'h00000003, 32'h00000005, 4'b0000, 4'b0001, 4'b0000};
      vt[2]  = '{4'b0000, 32'h00000003, 32'h00000005, 4'b0000, 4'b0001, 4'b0000};
      vt[3]  = '{4'b0000, 32'h00000003, 32'h00000005, 4'b0001, 4'b0001, 4'b0000};
      vt[4]  = '{4'b0000, 32'h00000003, 32'h00000005, 4'b0001, 4'b0001, 4'b0000};
      vt[5]  = '{4'b0000, 32'h00000003, 32'h00000005, 4'b0001, 4'b0001, 4'b0000};
      vt[6]  = '{4'b0000, 32'h00000003, 32'h00000005, 4'b0001, 4'b0001, 4'b0000};
      vt[7]  = '{4'b0000, 32'h00000003, 32'h00000005, 4'b0001, 4'b0001, 4'b0000};
      vt[8]  = '{4'b0000, 32'h00000003, 32'h00000005, 4'b0000, 4'b0000, 4'b0001};
      vt[9]  = '{4'b0000, 32'h00000003, 32'h00000005, 4'b0000, 4'b0000, 4'b0000};
      vt[10] = '{4'b1000, 32'h02000003, 32'h00000005, 4'b0000, 4'b1000, 4'b0000};
      vt[11] = '{4'b0000, 32'h02000003, 32'h00000005, 4'b0000, 4'b1000, 4'b0000};
      vt[12] = '{4'b0000, 32'h02000003, 32'h00000005, 4'b0000, 4'b0000, 4'b1000};
      vt[13] = '{4'b0000, 32'h00000003, 32'h00000005, 4'b0000, 4'b0000, 4'b0000};
      vt[14] = '{4'b1000, 32'h00000003, 32'h00000005, 4'b0000, 4'b0000, 4'b1000};
      vt[15] = '{4'b0000, 32'h00000003, 32'h00000005, 4'b0000, 4'b0000, 4'b0000};
      for (int i = 0; i < 16; i++) begin
         dcfg = vt[i].d;
         wcfg = vt[i].w;
         step(1'b0, vt[i].t);
         chk($sformatf("vec%0d_syn", i), syn_r, vt[i].es);
         chk($sformatf("vec%0d_busy", i), busy_r, vt[i].eb);
         chk($sformatf("vec%0d_done", i), done_o, vt[i].ed);
      end

      // retrigger stretch on ch1: 10 held samples, W=16
      dcfg = '0; wcfg = 32'h00001000;
      cs = 0; cd = 0; cs2 = 0; cd2 = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, (i < 10) ? 4'b0010 : 4'b0000);
         cs += syn_r[1]; cd += done_r[1]; cs2 += syn_o[1]; cd2 += done_o[1];
      end
      chk("stretch_len", cs, 25);
      chk("stretch_done", cd, 1);
      chk("oneshot_len", cs2, 16);
      chk("oneshot_done", cd2, 1);

      // one-shot with held trigger on ch2: 1,1,0 repeating
      wcfg = 32'h00020000;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 4'b0100);
         chk($sformatf("rep_syn%0d", i), syn_o[2], (i % 3) != 2);
         chk($sformatf("rep_done%0d", i), done_o[2], (i % 3) == 2);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 4'h0);

      // config changed mid-pulse has no effect
      dcfg = 32'h00000001; wcfg = 32'h00000008;
      cs = 0; cd = 0;
      for (int i = 0; i < 13; i++) begin
         if (i == 3) wcfg = 32'h00000002;
         step(1'b0, (i == 0) ? 4'b0001 : 4'b0000);
         cs += syn_r[0]; cd += done_r[0];
      end
      chk("cfg_hold_len", cs, 8);
      chk("cfg_hold_done", cd, 1);

      // reset mid-ACTIVE truncates with no done
      wcfg = 32'h00000008;
      cs = 0; cd = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) wcfg = 32'h00000002;
         step(1'b0, (i == 0) ? 4'b0001 : 4'b0000);
         cs += syn_r[0];
      end
      step(1'b1, 4'h0);
      chk("trunc_syn", syn_r[0], 0);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 4'h0);
         cd += done_r[0] + done_o[0];
      end
      chk("trunc_len", cs, 4);
      chk("trunc_done", cd, 0);

      // maximum delay and width
      dcfg = 32'h0000FF00; wcfg = 32'h0000FF00;
      cs = 0; cd = 0;
      for (int i = 0; i < 520; i++) begin
         step(1'b0, (i == 0) ? 4'b0010 : 4'b0000);
         cs += syn_o[1]; cd += done_o[1];
      end
      chk("max_len", cs, 255);
      chk("max_done", cd, 1);
`else
      // holdoff: trigger during holdoff ignored, busy extends past done
      dcfg = '0; wcfg = 32'h00000002;
      cs = 0; cd = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, (i == 0 || i == 3) ? 4'b0001 : 4'b0000);
         cs += busy_o[0]; cd += done_o[0];
      end
      chk("hold_busy", cs, 6);
      chk("hold_done", cd, 1);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            for (int c = 0; c < 4; c++) begin
               dcfg[c*8 +: 8] = 8'($urandom_range(0, 5));
               wcfg[c*8 +: 8] = 8'($urandom_range(0, 5));
            end
         end
         step(($urandom_range(0, 99) == 0), 4'($urandom) & 4'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
